mem_arbiter: RTL

- Owns the single multi-cycle main-memory port and shares it among three requesters: I-cache miss fill, D-cache miss fill, and D-cache write-through stores.
- Sequences each 8-word block fill: it issues reads, steers returning words into the selected cache's data array, and pulses that cache's tag write on the last word.
- Sits between both cache tag/data arrays and the memory model. Its busy outputs feed the pipeline stall logic.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_fill_sequencer.sv | 65 ++++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter and its block-fill sequencer.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FILL_I = 2'd2,
        ST_FILL_D = 2'd3
    } arb_state_e;

    localparam int BLK_WORDS  = 8;
    localparam int RD_LATENCY = 4;
    localparam int WORD_SHIFT = 1;

    localparam int REQ_WR  = 0;
    localparam int REQ_D   = 1;
    localparam int REQ_I   = 2;
    localparam int NUM_REQ = 3;

    // Fixed priority: the lowest requester index wins.
    function automatic logic [NUM_REQ-1:0] prio_grant(input logic [NUM_REQ-1:0] req);
        logic [NUM_REQ-1:0] g;
        g = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req[k] && (g == {NUM_REQ{1'b0}})) begin
                g[k] = 1'b1;
            end else begin
                g[k] = g[k];
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_arbiter_fill_sequencer.sv
// Block-fill sequencer: issue/receive word counters, word address generation and
// last-word detection, shared by the I-cache and D-cache fills.
module mem_arbiter_fill_sequencer
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int WORDS  = BLK_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              rdata_valid_i,
    output logic              issue_o,
    output logic [ADDR_W-1:0] issue_addr_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic              rcv_o,
    output logic              last_o
);

    localparam int CNT_W = $clog2(WORDS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

    logic [CNT_W-1:0] iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0] rcv_cnt_q, rcv_cnt_d;

    // Returns are counted rather than timed, so memory latency jitter is harmless.
    always_comb begin
        issue_o      = active_i && (iss_cnt_q < CNT_FULL);
        rcv_o        = active_i && rdata_valid_i;
        last_o       = rcv_o && (rcv_cnt_q == CNT_LAST);
        issue_addr_o = base_i | (ADDR_W'(iss_cnt_q) << WORD_SHIFT);
        fill_addr_o  = base_i | (ADDR_W'(rcv_cnt_q) << WORD_SHIFT);
        iss_cnt_d    = iss_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        if (!active_i || last_o) begin
            iss_cnt_d = {CNT_W{1'b0}};
            rcv_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (issue_o) begin
                iss_cnt_d = iss_cnt_q + CNT_W'(1);
            end else begin
                iss_cnt_d = iss_cnt_q;
            end
            if (rcv_o) begin
                rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
            end else begin
                rcv_cnt_d = rcv_cnt_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_cnt_q <= {CNT_W{1'b0}};
            rcv_cnt_q <= {CNT_W{1'b0}};
        end else begin
            iss_cnt_q <= iss_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter: write-through stores > D-cache fill > I-cache fill,
// each transaction runs to completion before the next is arbitrated.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = BLK_WORDS,
    parameter int MEM_LAT = RD_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdata_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              i_data_we,
    output logic              d_data_we,
    output logic              i_tag_we,
    output logic              d_tag_we,
    output logic              i_busy,
    output logic              d_busy
);

    localparam int OFF_BITS = $clog2(WORDS) + WORD_SHIFT;
    localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W - OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

    if (MEM_LAT < 1 || WORDS < 2) begin : g_param_check
        $error("mem_arbiter: MEM_LAT must be >= 1 and WORDS >= 2");
    end

    arb_state_e state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [NUM_REQ-1:0] req_s, grant_s;
    logic fill_active_s, seq_issue_s, seq_rcv_s, seq_last_s;
    logic [ADDR_W-1:0] seq_issue_addr_s, seq_fill_addr_s;

    assign req_s[REQ_WR] = wr_req;
    assign req_s[REQ_D]  = d_miss;
    assign req_s[REQ_I]  = i_miss;
    assign grant_s       = prio_grant(req_s);
    assign fill_active_s = (state_q == ST_FILL_I) || (state_q == ST_FILL_D);

    mem_arbiter_fill_sequencer #(
        .ADDR_W(ADDR_W),
        .WORDS (WORDS)
    ) u_fill_seq (
        .clk          (clk),
        .rst          (rst),
        .active_i     (fill_active_s),
        .base_i       (base_q),
        .rdata_valid_i(mem_rdata_valid),
        .issue_o      (seq_issue_s),
        .issue_addr_o (seq_issue_addr_s),
        .fill_addr_o  (seq_fill_addr_s),
        .rcv_o        (seq_rcv_s),
        .last_o       (seq_last_s)
    );

    // Next-state and block-base capture.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s[REQ_WR]) begin
                    state_d = ST_WRITE;
                    base_d  = wr_addr & BASE_MASK;
                end else if (grant_s[REQ_D]) begin
                    state_d = ST_FILL_D;
                    base_d  = d_miss_addr & BASE_MASK;
                end else if (grant_s[REQ_I]) begin
                    state_d = ST_FILL_I;
                    base_d  = i_miss_addr & BASE_MASK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_FILL_I, ST_FILL_D: begin
                if (seq_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output steering; the inactive cache never sees a write enable.
    always_comb begin
        wr_ack    = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        fill_addr = {ADDR_W{1'b0}};
        i_data_we = 1'b0;
        d_data_we = 1'b0;
        i_tag_we  = 1'b0;
        d_tag_we  = 1'b0;
        i_busy    = 1'b0;
        d_busy    = 1'b0;
        case (state_q)
            ST_IDLE: wr_ack = 1'b0;
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                wr_ack    = 1'b1;
            end
            ST_FILL_I: begin
                mem_en    = seq_issue_s;
                mem_addr  = seq_issue_s ? seq_issue_addr_s : {ADDR_W{1'b0}};
                fill_addr = seq_fill_addr_s;
                i_data_we = seq_rcv_s;
                i_tag_we  = seq_last_s;
                i_busy    = 1'b1;
            end
            ST_FILL_D: begin
                mem_en    = seq_issue_s;
                mem_addr  = seq_issue_s ? seq_issue_addr_s : {ADDR_W{1'b0}};
                fill_addr = seq_fill_addr_s;
                d_data_we = seq_rcv_s;
                d_tag_we  = seq_last_s;
                d_busy    = 1'b1;
            end
            default: wr_ack = 1'b0;
        endcase
    end

    // State and base-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

endmodule
